// File: rtl/interp_pkg.sv
// Shared constants and state encoding for the interpolation window feeder.
// Kept separate so the tap-filter blocks downstream can share the same definitions.
package interp_pkg;

   localparam int unsigned NTAPS      = 8;
   localparam int unsigned FRAC_W     = 4;
   localparam int unsigned CENTER_TAP = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_e;

endpackage

// File: rtl/interp_shift_window.sv
// History shift register for the sliding window: entry 0 is oldest, entry DEPTH-1 newest.
// load_first starts a fresh row, clearing stale history below the new top sample.
module interp_shift_window #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_shift,
   input  logic                  i_load_first,
   input  logic [DW-1:0]         i_data,
   output logic [DEPTH*DW-1:0]   o_win
);

   logic [DW-1:0] r_win [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < DEPTH; k++) r_win[k] <= '0;
      end else if (i_load_first) begin
         for (int unsigned k = 0; k < DEPTH - 1; k++) r_win[k] <= '0;
         r_win[DEPTH-1] <= i_data;
      end else if (i_shift) begin
         for (int unsigned k = 0; k < DEPTH - 1; k++) r_win[k] <= r_win[k+1];
         r_win[DEPTH-1] <= i_data;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign o_win[g*DW +: DW] = r_win[g];
   end

endmodule

// File: rtl/interp_window_feeder.sv
// Builds sliding NTAPS-sample windows from a valid/ready sample stream, one registered
// window per output position, tagged with the row's fractional phase.
module interp_window_feeder #(
   parameter int unsigned IW      = 10,
   parameter int unsigned DW      = 32,
   parameter int unsigned NTAPS   = 8,
   parameter int unsigned ROW_LEN = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [IW-1:0]                     s_data,
   input  logic                              s_sol,
   input  logic [interp_pkg::FRAC_W-1:0]     s_frac,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [NTAPS*DW-1:0]               m_x,
   output logic [interp_pkg::FRAC_W-1:0]     m_frac,
   output logic                              m_last,
   output logic                              err
);

   import interp_pkg::*;

   localparam int unsigned HIST   = NTAPS - 1;
   localparam int unsigned FILL_W = 3;
   localparam int unsigned POS_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(HIST - 1);
   localparam logic [POS_W-1:0]  POS_LAST = POS_W'(ROW_LEN - 1);

   state_e                    r_state, w_state_nxt;
   logic [FILL_W-1:0]         r_fill_cnt, w_fill_nxt;
   logic [POS_W-1:0]          r_pos_cnt, w_pos_nxt;
   logic [FRAC_W-1:0]         r_frac, w_frac_nxt;
   logic                      r_err, w_err_nxt;

   logic                      r_m_valid;
   logic [NTAPS*DW-1:0]       r_m_x;
   logic [FRAC_W-1:0]         r_m_frac;
   logic                      r_m_last;

   logic                      w_accept;
   logic                      w_shift;
   logic                      w_load_first;
   logic                      w_out_load;
   logic                      w_out_last;
   logic [DW-1:0]             w_new;
   logic [HIST*DW-1:0]        w_win;

   // Only STREAM is throttled by the output register; filling never touches it.
   assign s_ready  = (r_state != STREAM) || !r_m_valid || m_ready;
   assign w_accept = s_valid && s_ready;
   assign w_new    = DW'(s_data);

   interp_shift_window #(
      .DW    (DW),
      .DEPTH (HIST)
   ) u_win (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_shift      (w_shift),
      .i_load_first (w_load_first),
      .i_data       (w_new),
      .o_win        (w_win)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_fill_cnt <= '0;
         r_pos_cnt  <= '0;
         r_frac     <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_fill_cnt <= w_fill_nxt;
         r_pos_cnt  <= w_pos_nxt;
         r_frac     <= w_frac_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_fill_nxt   = r_fill_cnt;
      w_pos_nxt    = r_pos_cnt;
      w_frac_nxt   = r_frac;
      w_err_nxt    = r_err;
      w_shift      = 1'b0;
      w_load_first = 1'b0;
      w_out_load   = 1'b0;
      w_out_last   = 1'b0;

      // A start-of-row always restarts filling, whatever the current state.
      if (w_accept && s_sol) begin
         w_frac_nxt   = s_frac;
         w_load_first = 1'b1;
         w_fill_nxt   = FILL_W'(1);
         w_pos_nxt    = '0;
         w_state_nxt  = FILL;
         if (r_state != IDLE) w_err_nxt = 1'b1;
      end else if (w_accept) begin
         case (r_state)
            IDLE: begin
               w_err_nxt = 1'b1;
            end
            FILL: begin
               w_shift    = 1'b1;
               w_fill_nxt = r_fill_cnt + FILL_W'(1);
               if (r_fill_cnt == FILL_PRE) w_state_nxt = STREAM;
            end
            STREAM: begin
               w_shift    = 1'b1;
               w_out_load = 1'b1;
               w_out_last = (r_pos_cnt == POS_LAST);
               if (w_out_last) begin
                  w_state_nxt = IDLE;
                  w_pos_nxt   = '0;
                  w_fill_nxt  = '0;
               end else begin
                  w_pos_nxt = r_pos_cnt + POS_W'(1);
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Output register: loads on a STREAM accept, drains on m_ready otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_valid <= 1'b0;
         r_m_x     <= '0;
         r_m_frac  <= '0;
         r_m_last  <= 1'b0;
      end else if (w_out_load) begin
         r_m_valid <= 1'b1;
         r_m_x     <= {w_new, w_win};
         r_m_frac  <= r_frac;
         r_m_last  <= w_out_last;
      end else if (m_ready) begin
         r_m_valid <= 1'b0;
      end
   end

   assign m_valid = r_m_valid;
   assign m_x     = r_m_x;
   assign m_frac  = r_m_frac;
   assign m_last  = r_m_last;
   assign err     = r_err;

endmodule
